// File: rtl/hanoi_move_seq_pkg.sv
// Shared types and helpers for the Hanoi move sequencer.
// Peg ids, FSM states and the 1<->2 peg relabelling.
package hanoi_pkg;

  typedef logic [1:0] peg_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam peg_t PEG_SRC = 2'd0;
  localparam peg_t PEG_DST = 2'd2;

  function automatic peg_t peg_swap12(
    input peg_t p
  );
    peg_t r;
    unique case (p)
      2'd1:    r = 2'd2;
      2'd2:    r = 2'd1;
      default: r = p;
    endcase
    return r;
  endfunction

  function automatic peg_t mod3(
    input logic [15:0] v
  );
    logic [15:0] r;
    r = v % 16'd3;
    return r[1:0];
  endfunction

endpackage

// File: rtl/hanoi_move_seq_if.sv
// Move handshake and status bundle of the sequencer.
// master = sequencer side, slave = consumer side.
interface hanoi_move_seq_if
  import hanoi_pkg::*;
#(
  parameter int S = 3
);
  localparam int CW = $clog2(S + 1);

  logic              start;
  peg_t              fr;
  peg_t              to;
  logic              move_valid;
  logic              move_ready;
  logic [S-1:0]      move_idx;
  logic [3*CW-1:0]   peg_cnt;
  logic              busy;
  logic              done;

  modport master (
    input  start,
    input  move_ready,
    output fr,
    output to,
    output move_valid,
    output move_idx,
    output peg_cnt,
    output busy,
    output done
  );

  modport slave (
    output start,
    output move_ready,
    input  fr,
    input  to,
    input  move_valid,
    input  move_idx,
    input  peg_cnt,
    input  busy,
    input  done
  );

endinterface

// File: rtl/hanoi_move_seq_move_calc.sv
// Closed-form Hanoi move k -> (fr, to).
// Even ring counts relabel pegs 1/2 so the tower lands on peg 2.
module hanoi_move_calc
  import hanoi_pkg::*;
#(
  parameter int S = 3
) (
  input  logic [S-1:0] k,
  output peg_t         fr,
  output peg_t         to
);

  logic [S-1:0] lo;
  logic [S-1:0] hi;
  logic [S:0]   hi1;
  peg_t         raw_fr;
  peg_t         raw_to;

  // raw pegs from the bit tricks, widened so k=2^S-1 does not wrap
  always_comb begin
    lo     = k & (k - 1'b1);
    hi     = k | (k - 1'b1);
    hi1    = {1'b0, hi} + 1'b1;
    raw_fr = mod3(16'(lo));
    raw_to = mod3(16'(hi1));
  end

  // parity relabel
  always_comb begin
    fr = raw_fr;
    to = raw_to;
    if ((S % 2) == 0) begin
      fr = peg_swap12(raw_fr);
      to = peg_swap12(raw_to);
    end
  end

endmodule

// File: rtl/hanoi_move_seq.sv
// Hanoi move sequencer: one optimal move per handshake,
// plus per-peg ring counts, all outputs registered.
module hanoi_move_seq
  import hanoi_pkg::*;
#(
  parameter int S = 3
) (
  input logic             clk,
  input logic             rst,
  hanoi_move_seq_if.master m
);

  localparam int          CW     = $clog2(S + 1);
  localparam logic [S-1:0] K_LAST = {S{1'b1}};
  localparam logic [S-1:0] K_ONE  = S'(1);
  localparam logic [CW-1:0] C_ALL = CW'(S);

  state_t        state;
  logic [S-1:0]  k;
  logic [S-1:0]  k_next;
  logic [CW-1:0] cnt [3];
  peg_t          c_fr;
  peg_t          c_to;
  logic          hs;
  logic          load;

  assign hs   = m.move_valid & m.move_ready;
  assign load = m.start & (state != RUN);

  // next move index; the calc sees it so fr/to register with k
  always_comb begin
    k_next = k;
    if (load) begin
      k_next = K_ONE;
    end else if (state == RUN && hs && k != K_LAST) begin
      k_next = k + 1'b1;
    end
  end

  hanoi_move_calc #(
    .S(S)
  ) u_calc (
    .k (k_next),
    .fr(c_fr),
    .to(c_to)
  );

  // sequencer FSM with registered move outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      k            <= '0;
      m.fr         <= PEG_SRC;
      m.to         <= PEG_SRC;
      m.move_valid <= 1'b0;
      m.move_idx   <= '0;
      m.busy       <= 1'b0;
      m.done       <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (m.start) begin
            state        <= RUN;
            k            <= k_next;
            m.fr         <= c_fr;
            m.to         <= c_to;
            m.move_idx   <= k_next;
            m.move_valid <= 1'b1;
            m.busy       <= 1'b1;
            m.done       <= 1'b0;
          end
        end
        RUN: begin
          if (hs) begin
            if (k == K_LAST) begin
              state        <= DONE;
              m.move_valid <= 1'b0;
              m.move_idx   <= '0;
              m.busy       <= 1'b0;
              m.done       <= 1'b1;
            end else begin
              k          <= k_next;
              m.fr       <= c_fr;
              m.to       <= c_to;
              m.move_idx <= k_next;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // per-peg ring counts follow each accepted move
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt[0] <= C_ALL;
      cnt[1] <= '0;
      cnt[2] <= '0;
    end else if (load) begin
      cnt[0] <= C_ALL;
      cnt[1] <= '0;
      cnt[2] <= '0;
    end else if (hs) begin
      for (int p = 0; p < 3; p++) begin
        if (m.fr == peg_t'(p)) begin
          cnt[p] <= cnt[p] - 1'b1;
        end else if (m.to == peg_t'(p)) begin
          cnt[p] <= cnt[p] + 1'b1;
        end
      end
    end
  end

  assign m.peg_cnt = {cnt[2], cnt[1], cnt[0]};

endmodule

// File: tb/tb_hanoi_move_seq.sv
// Bench for hanoi_move_seq: table vectors, stack-based
// reference model, stalls, restart and async reset.
module tb_hanoi_move_seq;

  typedef struct {
    int fr;
    int to;
    int idx;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start_r = 1'b0;
  logic ready_r = 1'b0;
  int   sel = 3;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  hanoi_move_seq_if #(.S(3)) if3 ();
  hanoi_move_seq_if #(.S(2)) if2 ();
  hanoi_move_seq_if #(.S(1)) if1 ();

  assign if3.start      = start_r & (sel == 3);
  assign if3.move_ready = ready_r & (sel == 3);
  assign if2.start      = start_r & (sel == 2);
  assign if2.move_ready = ready_r & (sel == 2);
  assign if1.start      = start_r & (sel == 1);
  assign if1.move_ready = ready_r & (sel == 1);

  hanoi_move_seq #(.S(3)) u3 (.clk(clk), .rst(rst), .m(if3.master));
  hanoi_move_seq #(.S(2)) u2 (.clk(clk), .rst(rst), .m(if2.master));
  hanoi_move_seq #(.S(1)) u1 (.clk(clk), .rst(rst), .m(if1.master));

  int o_fr, o_to, o_v, o_busy, o_done, o_idx;
  int o_c0, o_c1, o_c2;

  always_comb begin
    o_fr   = int'(if3.fr);
    o_to   = int'(if3.to);
    o_v    = int'(if3.move_valid);
    o_busy = int'(if3.busy);
    o_done = int'(if3.done);
    o_idx  = int'(if3.move_idx);
    o_c0   = int'(if3.peg_cnt[1:0]);
    o_c1   = int'(if3.peg_cnt[3:2]);
    o_c2   = int'(if3.peg_cnt[5:4]);
    if (sel == 2) begin
      o_fr   = int'(if2.fr);
      o_to   = int'(if2.to);
      o_v    = int'(if2.move_valid);
      o_busy = int'(if2.busy);
      o_done = int'(if2.done);
      o_idx  = int'(if2.move_idx);
      o_c0   = int'(if2.peg_cnt[1:0]);
      o_c1   = int'(if2.peg_cnt[3:2]);
      o_c2   = int'(if2.peg_cnt[5:4]);
    end
    if (sel == 1) begin
      o_fr   = int'(if1.fr);
      o_to   = int'(if1.to);
      o_v    = int'(if1.move_valid);
      o_busy = int'(if1.busy);
      o_done = int'(if1.done);
      o_idx  = int'(if1.move_idx);
      o_c0   = int'(if1.peg_cnt[0]);
      o_c1   = int'(if1.peg_cnt[1]);
      o_c2   = int'(if1.peg_cnt[2]);
    end
  end

  task automatic chk(input string nm, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic chk_cnt(input string nm, input int c0, input int c1, input int c2);
    chk({nm, " peg0"}, o_c0, c0);
    chk({nm, " peg1"}, o_c1, c1);
    chk({nm, " peg2"}, o_c2, c2);
  endtask

  task automatic chk_done(input string nm, input int s);
    chk({nm, " valid"}, o_v, 0);
    chk({nm, " done"}, o_done, 1);
    chk({nm, " busy"}, o_busy, 0);
    chk({nm, " idx"}, o_idx, 0);
    chk_cnt(nm, 0, 0, s);
  endtask

  // reference model: iterative peg-stack solution
  int qfr[$];
  int qto[$];

  task automatic build(input int s);
    int stk [3][16];
    int h [3];
    int n, sp, d, a, b, src, dst;
    qfr.delete();
    qto.delete();
    h[0] = s;
    h[1] = 0;
    h[2] = 0;
    for (int i = 0; i < s; i++) stk[0][i] = s - i;
    n = (1 << s) - 1;
    for (int i = 1; i <= n; i++) begin
      sp = 0;
      for (int p = 0; p < 3; p++)
        if (h[p] > 0 && stk[p][h[p]-1] == 1) sp = p;
      if (i % 2 == 1) begin
        src = sp;
        dst = (s % 2 == 1) ? (sp + 2) % 3 : (sp + 1) % 3;
      end else begin
        a = (sp + 1) % 3;
        b = (sp + 2) % 3;
        if (h[a] == 0) begin
          src = b; dst = a;
        end else if (h[b] == 0) begin
          src = a; dst = b;
        end else if (stk[a][h[a]-1] < stk[b][h[b]-1]) begin
          src = a; dst = b;
        end else begin
          src = b; dst = a;
        end
      end
      d = stk[src][h[src]-1];
      h[src]--;
      stk[dst][h[dst]] = d;
      h[dst]++;
      qfr.push_back(src);
      qto.push_back(dst);
    end
  endtask

  // rmode: 0 always ready, 1 random, 2 pattern 1,0,0
  task automatic run_seq(input int s, input int rmode, input int start_at);
    int n, k, cyc, rdy, pulsed;
    int mc [3];
    build(s);
    n = (1 << s) - 1;
    mc[0] = s;
    mc[1] = 0;
    mc[2] = 0;
    pulsed = 0;
    @(negedge clk);
    start_r = 1'b1;
    @(negedge clk);
    start_r = 1'b0;
    k = 1;
    cyc = 0;
    while (k <= n && cyc < 400) begin
      chk("valid", o_v, 1);
      chk("idx", o_idx, k);
      chk("fr", o_fr, qfr[k-1]);
      chk("to", o_to, qto[k-1]);
      chk("busy", o_busy, 1);
      chk("done", o_done, 0);
      chk_cnt("run cnt", mc[0], mc[1], mc[2]);
      if (rmode == 0) rdy = 1;
      else if (rmode == 1) rdy = int'($urandom_range(0, 1));
      else rdy = (cyc % 3 == 0) ? 1 : 0;
      ready_r = rdy[0];
      start_r = 1'b0;
      if (start_at == k && pulsed == 0) begin
        start_r = 1'b1;
        pulsed = 1;
      end
      if (rdy == 1) begin
        mc[qfr[k-1]]--;
        mc[qto[k-1]]++;
        k++;
      end
      @(negedge clk);
      cyc++;
    end
    start_r = 1'b0;
    ready_r = 1'b0;
    if (k <= n) chk("sequence timeout", k, n + 1);
    chk_done("end", s);
  endtask

  vec_t tab [8];

  task automatic run_tab(input int s, input int n);
    @(negedge clk);
    start_r = 1'b1;
    @(negedge clk);
    start_r = 1'b0;
    ready_r = 1'b1;
    for (int i = 0; i < n; i++) begin
      chk("tab valid", o_v, 1);
      chk("tab fr", o_fr, tab[i].fr);
      chk("tab to", o_to, tab[i].to);
      chk("tab idx", o_idx, tab[i].idx);
      @(negedge clk);
    end
    ready_r = 1'b0;
    chk_done("tab end", s);
  endtask

  initial begin
    int hit;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst valid", o_v, 0);
    chk("rst idx", o_idx, 0);
    chk("rst fr", o_fr, 0);
    chk("rst to", o_to, 0);
    chk("rst busy", o_busy, 0);
    chk("rst done", o_done, 0);
    chk_cnt("rst cnt", 3, 0, 0);
    rst = 1'b1;

    // idle ignores move_ready
    ready_r = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle ready valid", o_v, 0);
    chk_cnt("idle ready cnt", 3, 0, 0);
    ready_r = 1'b0;

    tab[0] = '{0, 2, 1};
    tab[1] = '{0, 1, 2};
    tab[2] = '{2, 1, 3};
    tab[3] = '{0, 2, 4};
    tab[4] = '{1, 0, 5};
    tab[5] = '{1, 2, 6};
    tab[6] = '{0, 2, 7};
    sel = 3;
    run_tab(3, 7);

    tab[0] = '{0, 1, 1};
    tab[1] = '{0, 2, 2};
    tab[2] = '{1, 2, 3};
    sel = 2;
    run_tab(2, 3);

    // done is a level; ready alone does not restart
    sel = 3;
    ready_r = 1'b1;
    repeat (2) @(negedge clk);
    chk_done("done hold", 3);
    ready_r = 1'b0;

    run_seq(3, 2, 0);
    run_seq(3, 0, 3);

    // async reset with move 5 pending
    @(negedge clk);
    start_r = 1'b1;
    @(negedge clk);
    start_r = 1'b0;
    ready_r = 1'b1;
    hit = 0;
    for (int c = 0; c < 20 && hit == 0; c++) begin
      if (o_idx == 5) hit = 1;
      else @(negedge clk);
    end
    chk("reach idx5", hit, 1);
    ready_r = 1'b0;
    rst = 1'b0;
    #1;
    chk("mid rst valid", o_v, 0);
    chk("mid rst idx", o_idx, 0);
    chk("mid rst fr", o_fr, 0);
    chk("mid rst to", o_to, 0);
    chk("mid rst busy", o_busy, 0);
    chk("mid rst done", o_done, 0);
    chk_cnt("mid rst cnt", 3, 0, 0);
    @(negedge clk);
    rst = 1'b1;

    run_seq(3, 1, 0);
    run_seq(3, 1, 2);
    run_seq(3, 1, 0);

    sel = 1;
    run_seq(1, 0, 0);
    run_seq(1, 1, 1);
    sel = 2;
    run_seq(2, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
